sr_latch_driver: RTL
====================

# sr_latch_driver

Clocked initiator for the S/R interface of a NOR SR latch: converts single-cycle-accepted set/clear requests into mutually exclusive, width-controlled S/R pulses, then reads the latch's Q/Qn back to confirm the commanded state. Sits between control logic and any `sr_latch_nor` instance. It guarantees S=R=1 is never driven, and reports completion and errors.

## Interface
- `PULSE_CYC`, default 2: cycles S or R is held high; legal range 1..15.
- `SETTLE_CYC`, default 1: cycles with S=R=0 before readback; legal range 1..15.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `set_req` in 1: request Q=1; sampled only when `req_ready`=1.
- `clr_req` in 1: request Q=0; sampled only when `req_ready`=1.
- `req_ready` out 1: high in IDLE only.
- `latch_q` in 1: latch Q feedback.
- `latch_qn` in 1: latch Qn feedback.
- `s_out` out 1: drives latch S; registered.
- `r_out` out 1: drives latch R; registered.
- `done` out 1: one-cycle completion pulse.
- `ok` out 1: valid with `done`; 1 = readback matched.
- `err_code` out 2: sticky error; 00 none, 01 conflicting request, 10 readback mismatch.
- `err_clr` in 1: clears `err_code`.
- `target` out 1: last commanded value.

## Operation
- FSM states: IDLE, PULSE, SETTLE, CHECK.
- **IDLE, exactly one request high:**
  - Latch `target` (1 for set, 0 for clr).
  - Load the timer with PULSE_CYC and go to PULSE.
- **IDLE, both requests high:**
  - Stay in IDLE and drive nothing.
  - Next cycle: `done`=1, `ok`=0.
  - Set `err_code`=01 if `err_code` is currently 00.
- **IDLE, neither request high:** stay in IDLE.
- **PULSE:**
  - `s_out`=`target`, `r_out`=~`target`. Exactly one of them is high.
  - On timer expiry, load SETTLE_CYC and go to SETTLE.
- **SETTLE:** `s_out`=`r_out`=0. On timer expiry, go to CHECK.
- **CHECK:**
  - Sample the latch. Match means `latch_q`==`target` and `latch_qn`==~`target`.
  - Q==Qn counts as a mismatch.
  - Go to IDLE. Next cycle: `done`=1 and `ok`=match.
  - On mismatch, set `err_code`=10 if `err_code` is 00.
- Requests are level-sensitive and are not queued. Requests while busy are ignored. A request held high through `done` is accepted again.
- `err_code` holds the first error until `err_clr`. If `err_clr` and a new error occur in the same cycle, the new error is recorded.
- `s_out`&`r_out`=1 is unreachable in every state, including during reset.

## Timing
- **Reset values (asynchronous):**
  - State IDLE and `req_ready`=1.
  - `s_out`=`r_out`=0.
  - `done`=0, `ok`=0, `err_code`=00, `target`=0.
- **Acceptance at edge ending cycle N:**
  - PULSE covers cycles N+1..N+PULSE_CYC.
  - SETTLE covers the next SETTLE_CYC cycles.
  - CHECK falls on cycle N+PULSE_CYC+SETTLE_CYC+1.
  - `done` and `req_ready` are high on cycle N+PULSE_CYC+SETTLE_CYC+2.
- Defaults give `done` 5 cycles after acceptance. The earliest next acceptance is that same cycle.
- Conflict `done` occurs on cycle N+1. `req_ready` stays 1.
- Reset mid-operation drops `s_out`/`r_out` immediately. No `done` is generated. The latch keeps its state.
- `req_ready` is decoded from the state register, not registered separately.

## Structure
- Shared package `sr_drv_pkg`:
  - State encoding: IDLE=0, PULSE=1, SETTLE=2, CHECK=3.
  - `err_code` constants: ERR_NONE, ERR_CONFLICT, ERR_MISMATCH.
  - Timer width constant: 4 bits.
- Sub-module `sr_drv_timer`: 4-bit loadable down-counter with load, value and `expire` (count==1 while enabled). It is shared by PULSE and SETTLE.
- All outputs are registered except `req_ready`.

## Test plan
- Set with defaults, latch model attached:
  - `set_req` pulsed at cycle 0 → `s_out`=1 on cycles 1–2, `r_out`=0 throughout.
  - `done`=1 and `ok`=1 on cycle 5; Q=1, Qn=0; `target`=1; `err_code`=00.
- Clear after set → `r_out` high for 2 cycles, `done`/`ok`=1 five cycles after acceptance, Q=0.
- `set_req`=`clr_req`=1 in IDLE:
  - `s_out`=`r_out`=0 throughout.
  - Next cycle `done`=1, `ok`=0, `err_code`=01.
  - A later mismatch does not overwrite 01.
- Latch feedback forced Q=0/Qn=0 during a set → `done`=1, `ok`=0, `err_code`=10. `err_clr` returns it to 00.
- `rst_n` low on the second PULSE cycle → `s_out`=0 immediately, no `done`, `req_ready`=1 after release.
- PULSE_CYC=1, SETTLE_CYC=3, back-to-back held `set_req`:
  - Pulse width is 1 cycle and `done` occurs every 6 cycles.
  - An assertion confirms `s_out`&`r_out` is never 1.

Source files
------------

// File: rtl/sr_drv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sr_drv_pkg
// Brief    : Shared types and constants for the SR latch driver.
// Revision : 1.0
// ============================================================================
package sr_drv_pkg;

    localparam int TIMER_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PULSE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_CHECK  = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_CONFLICT = 2'b01;
    localparam logic [1:0] ERR_MISMATCH = 2'b10;

endpackage : sr_drv_pkg
`default_nettype wire

// File: rtl/sr_drv_timer.sv
`default_nettype none
// ============================================================================
// Module   : sr_drv_timer
// Brief    : Loadable down-counter; expires when count reaches 1 while enabled.
// Revision : 1.0
// ============================================================================
module sr_drv_timer
    import sr_drv_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic [TIMER_W-1:0] i_value,
    input  logic               i_en,
    output logic               o_expire
);

    localparam logic [TIMER_W-1:0] C_ONE = {{(TIMER_W-1){1'b0}}, 1'b1};

    logic [TIMER_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - C_ONE;
        end
    end

    assign o_expire = i_en && (r_count == C_ONE);

endmodule : sr_drv_timer
`default_nettype wire

// File: rtl/sr_latch_driver.sv
`default_nettype none
// ============================================================================
// Module   : sr_latch_driver
// Brief    : Drives exclusive width-controlled S/R pulses into a NOR SR latch
//            and verifies the resulting Q/Qn.
// Revision : 1.0
// ============================================================================
module sr_latch_driver
    import sr_drv_pkg::*;
#(
    parameter int PULSE_CYC  = 2,
    parameter int SETTLE_CYC = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set_req,
    input  logic       clr_req,
    output logic       req_ready,
    input  logic       latch_q,
    input  logic       latch_qn,
    output logic       s_out,
    output logic       r_out,
    output logic       done,
    output logic       ok,
    output logic [1:0] err_code,
    input  logic       err_clr,
    output logic       target
);

    localparam logic [TIMER_W-1:0] C_PULSE  = PULSE_CYC[TIMER_W-1:0];
    localparam logic [TIMER_W-1:0] C_SETTLE = SETTLE_CYC[TIMER_W-1:0];

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_s_out;
    logic               r_r_out;
    logic               r_done;
    logic               r_ok;
    logic [1:0]         r_err_code;
    logic               r_target;
    logic               w_target_nxt;
    logic               w_load;
    logic [TIMER_W-1:0] w_load_val;
    logic               w_timer_en;
    logic               w_expire;
    logic               w_conflict;
    logic               w_check;
    logic               w_match;
    logic               w_new_err;
    logic [1:0]         w_new_code;

    sr_drv_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_load),
        .i_value  (w_load_val),
        .i_en     (w_timer_en),
        .o_expire (w_expire)
    );

    assign w_timer_en = (r_state == ST_PULSE) || (r_state == ST_SETTLE);
    // Q==Qn can never satisfy both terms, so it reads as a mismatch.
    assign w_match    = (latch_q == r_target) && (latch_qn == ~r_target);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        w_load       = 1'b0;
        w_load_val   = C_PULSE;
        w_conflict   = 1'b0;
        w_check      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (set_req && clr_req) begin
                    w_conflict = 1'b1;
                end else if (set_req || clr_req) begin
                    w_target_nxt = set_req;
                    w_load       = 1'b1;
                    w_load_val   = C_PULSE;
                    w_state_nxt  = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (w_expire) begin
                    w_load      = 1'b1;
                    w_load_val  = C_SETTLE;
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (w_expire) begin
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                w_check     = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_new_err  = w_conflict || (w_check && !w_match);
    assign w_new_code = w_conflict ? ERR_CONFLICT : ERR_MISMATCH;

    // S/R derive from the next state so the pulse starts on the first PULSE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_out    <= 1'b0;
            r_r_out    <= 1'b0;
            r_done     <= 1'b0;
            r_ok       <= 1'b0;
            r_err_code <= ERR_NONE;
            r_target   <= 1'b0;
        end else begin
            r_s_out  <= (w_state_nxt == ST_PULSE) && w_target_nxt;
            r_r_out  <= (w_state_nxt == ST_PULSE) && !w_target_nxt;
            r_done   <= w_conflict || w_check;
            r_ok     <= w_check && w_match;
            r_target <= w_target_nxt;
            if (err_clr) begin
                r_err_code <= w_new_err ? w_new_code : ERR_NONE;
            end else if ((r_err_code == ERR_NONE) && w_new_err) begin
                r_err_code <= w_new_code;
            end
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign s_out     = r_s_out;
    assign r_out     = r_r_out;
    assign done      = r_done;
    assign ok        = r_ok;
    assign err_code  = r_err_code;
    assign target    = r_target;

endmodule : sr_latch_driver
`default_nettype wire
